// File: rtl/alu_mult_seq_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// The master drives operands and start; the slave returns busy, done and the HI/LO product.
interface alu_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signmul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, signmul, a, b, input busy, done, hi, lo);
  modport slave  (input start, signmul, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative radix-2 shift-add multiplier (MULT/MULTU) writing a 2*WIDTH-bit product to HI/LO.
// Optional macro ALU_MULT_EARLY_TERM_EN lets RUN finish as soon as the remaining multiplier is zero.
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  alu_mult_seq_if.slave      bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH);

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mplr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_run_exit;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // Magnitude of a possibly-signed operand; the most-negative value maps to itself read unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE_2W) : v;
  endfunction

  assign w_a_mag    = f_mag(bus.a, bus.signmul);
  assign w_b_mag    = f_mag(bus.b, bus.signmul);
  assign w_mplr_nxt = r_mplr >> 1;
  assign w_cnt_nxt  = r_cnt + ONE_C;

`ifdef ALU_MULT_EARLY_TERM_EN
  // mcand is already shifted into place, so stopping once no multiplier bits remain is exact.
  assign w_run_exit = (w_cnt_nxt == CNT_END) || (w_mplr_nxt == '0);
`else
  assign w_run_exit = (w_cnt_nxt == CNT_END);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplr  <= w_b_mag;
            r_neg   <= bus.signmul & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_mplr[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_mplr  <= w_mplr_nxt;
          r_cnt   <= w_cnt_nxt;
          if (w_run_exit) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          {r_hi, r_lo} <= f_apply_sign(r_acc, r_neg);
          r_done       <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Iterative radix-2 shift-add multiplier for MULT/MULTU. It is the counterpart of the ALU's sequential divider.
- Accepts a one-cycle start and runs WIDTH iterations.
- Writes the 2*WIDTH-bit product into the HI/LO registers and pulses done.
- Sits beside the ALU divide path and shares the HI/LO writeback path.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a multiply; sampled only in IDLE.
- signmul  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse; hi/lo are valid that cycle.
- hi  output  WIDTH  upper product half; holds until the next done.
- lo  output  WIDTH  lower product half; holds until the next done.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Internal acc, mcand, mplr, cnt, neg all cleared.
  - Reset mid-operation aborts it; no done is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - On a clk edge with start=1, load operand magnitudes:
    - If signmul and a[WIDTH-1]: mcand = -a, zero-extended to 2*WIDTH. Otherwise a, zero-extended.
    - mplr is |b| by the same rule, WIDTH bits.
  - neg = signmul & (a[MSB] ^ b[MSB]); acc=0; cnt=0; go to RUN.
  - done deasserts in IDLE except in the pulse cycle.
- RUN, per edge:
  - If mplr[0]: acc = acc + mcand, modulo 2^(2*WIDTH).
  - Then mcand <<= 1, mplr >>= 1, cnt += 1.
  - Exit to FIX on the edge where cnt reaches WIDTH.
- Magnitude of the most-negative value (0x80000000) is 0x80000000 read as unsigned; no overflow.
- FIX, one edge:
  - {hi,lo} = neg ? -acc : acc (two's complement, 2*WIDTH bits).
  - Set done=1; go to IDLE.
- done is registered and high for exactly the cycle after the FIX edge; cleared on the next edge.
- busy is combinational from state.
- Latency (no macro): start seen at edge E0 → done high in the cycle after edge E0+WIDTH+1, i.e. 34 clocks for WIDTH=32.
- start while busy=1 is ignored, as is a change on a/b/signmul after start; no queueing.
- A start asserted during the done cycle (state IDLE) is accepted normally. The done pulse still completes.
- hi/lo change only at the FIX edge or on reset.

Optional Feature:
- Macro: ALU_MULT_EARLY_TERM_EN.
- Defined: RUN also exits to FIX on the edge where the post-shift mplr equals 0.
  - Always at least 1 RUN cycle.
  - The result is identical to the full-length run because mcand is pre-shifted left.
  - Examples: b=2 → 2 RUN cycles; b=0 → 1 RUN cycle.
- Undefined: always exactly WIDTH RUN cycles; cnt is the only exit condition.

Test Plan:
- Unsigned 0xF0000000 × 0x00000002 (signmul=0) → hi=0x00000001, lo=0xE0000000. done exactly 34 clocks after start without the macro; busy high for the 33 cycles before done.
- Signed 0xF0000000 × 0x00000002 → hi=0xFFFFFFFF, lo=0xE0000000. Signed 0xFFFFFFFF × 0xFFFFFFFF → hi=0, lo=1.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Signed 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- Start 7×9, pulse start again with 3×3 at cycle 10 → second start ignored; result hi=0, lo=63; one done pulse only.
- Start 5×5, drive rst=0 at cycle 12 → busy/done/hi/lo drop to 0 immediately. No done follows; a new 5×5 afterwards gives lo=25.
- With ALU_MULT_EARLY_TERM_EN: 0xF0000000 × 2 unsigned → same product, done 4 clocks after start. b=0 → product 0, done 3 clocks after start.
